// File: rtl/rv_insn_encoder.sv
// rtl/rv_insn_encoder.sv - RV32 R/I/U field packer with LI expansion and sequential word addressing
module rv_insn_encoder #(
    parameter int          ADDR_W     = 12,
    parameter int unsigned RESET_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_fmt,
    input  logic [6:0]        req_opcode,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_func3,
    input  logic [6:0]        req_func7,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err
);

    localparam logic [1:0] FMT_R  = 2'd0;
    localparam logic [1:0] FMT_I  = 2'd1;
    localparam logic [1:0] FMT_U  = 2'd2;

    localparam logic [6:0] OP_IMM = 7'h13;
    localparam logic [6:0] OP_LUI = 7'h37;

    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RESET_ADDR);
    localparam logic [ADDR_W-1:0] WORD_INC = ADDR_W'(4);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LI2  = 1'b1
    } state_t;

    state_t      state;
    logic [4:0]  li_rd;
    logic [11:0] li_lo;

    logic        accept;
    logic        consume;
    logic [31:0] enc_word;
    logic        imm_err;
    logic        go_li2;
    logic        li_fits;
    logic [19:0] li_hi;

    assign req_ready = !rst && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept    = req_valid && req_ready;
    assign consume   = out_valid && out_ready;

    // LI fits a single ADDI when bits [31:11] are a pure sign extension
    assign li_fits = (&req_imm[31:11]) || !(|req_imm[31:11]);
    // (imm + 0x800) >> 12 without a 32-bit adder: the +0x800 only carries out of bit 11
    assign li_hi   = req_imm[31:12] + {19'd0, req_imm[11]};

    // Encode the request into the word loaded on accept; flag out-of-range immediates
    always_comb begin
        enc_word = '0;
        imm_err  = 1'b0;
        go_li2   = 1'b0;
        case (req_fmt)
            FMT_R: begin
                enc_word = {req_func7, req_rs2, req_rs1, req_func3, req_rd, req_opcode};
            end
            FMT_I: begin
                enc_word = {req_imm[11:0], req_rs1, req_func3, req_rd, req_opcode};
                imm_err  = !li_fits;
            end
            FMT_U: begin
                enc_word = {req_imm[19:0], req_rd, req_opcode};
                imm_err  = |req_imm[31:20];
            end
            default: begin
                if (li_fits) begin
                    enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
                end else begin
                    enc_word = {li_hi, req_rd, OP_LUI};
                    go_li2   = |req_imm[11:0];
                end
            end
        endcase
    end

    // Output register, word address, LI second-half sequencing and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            out_word  <= '0;
            out_addr  <= RST_ADDR;
            err       <= 1'b0;
            li_rd     <= '0;
            li_lo     <= '0;
        end else begin
            if (consume) begin
                out_addr <= out_addr + WORD_INC;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        out_valid <= 1'b1;
                        out_word  <= enc_word;
                        if (imm_err) begin
                            err <= 1'b1;
                        end
                        if (go_li2) begin
                            state <= S_LI2;
                            li_rd <= req_rd;
                            li_lo <= req_imm[11:0];
                        end
                    end else if (consume) begin
                        out_valid <= 1'b0;
                    end
                end
                S_LI2: begin
                    // LUI is pending in the output register; swap in the ADDI as it leaves
                    if (consume) begin
                        out_word <= {li_lo, li_rd, 3'b000, li_rd, OP_IMM};
                        state    <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
